// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared pipeline types and constants for the unified memory port arbiter
package mem_port_arbiter_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
endpackage

// File: rtl/mem_port_arbiter_starve.sv
// mem_port_arbiter_starve: saturating IF-starvation counter
//  clk, rst_n  clock, asynchronous active-low reset
//  clr         clear to 0 (wins over inc)
//  inc         increment, saturating at LIMIT
//  cnt         current count
module mem_port_arbiter_starve #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != 4'(LIMIT)) cnt <= cnt + 4'd1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the IF and MEM pipeline stages
//  clk, rst_n                 clock, asynchronous active-low reset
//  if_req/if_addr             fetch request, held until if_done
//  if_done/if_rdata/if_stall  fetch completion pulse, instruction, PC hold
//  d_req/d_we/d_addr/d_wdata/d_wstrb  load/store request, held until d_done
//  d_done/d_rdata/d_stall     data completion pulse, load data, pipeline freeze
//  mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  registered memory command
//  mem_gnt                    command accepted
//  mem_rvalid/mem_rdata       single response per command
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = XLEN,
    parameter int DATA_W       = XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    arb_state_t state, state_nx;
    arb_owner_t owner;
    logic [3:0] starve_cnt;
    logic arb, pick_if, resp, st_inc, st_clr;
    // A completion cycle is a bubble for both requesters: the finishing one still
    // shows its old request, and holding the other back lets a re-requesting D
    // meet a waiting IF in the next arbitration so starvation is actually counted.
    always_comb begin
        arb      = state == ARB_IDLE && !if_done && !d_done && (if_req || d_req);
        pick_if  = if_req && (!d_req || starve_cnt == 4'(STARVE_LIMIT));
        resp     = mem_rvalid && (state == ARB_WAIT || (state == ARB_ISSUE && mem_gnt));
        st_inc   = arb && if_req && d_req && !pick_if;
        st_clr   = !if_req || (arb && pick_if);
        state_nx = resp ? ARB_IDLE :
                   arb ? ARB_ISSUE :
                   (state == ARB_ISSUE && mem_gnt) ? ARB_WAIT : state;
    end
    mem_port_arbiter_starve #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk(clk),
        .rst_n(rst_n),
        .clr(st_clr),
        .inc(st_inc),
        .cnt(starve_cnt)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ARB_IDLE;
        else state <= state_nx;
    // Command fields stay put after the grant so mem_we still tells a store apart in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_done <= resp && owner == OWN_IF;
            d_done  <= resp && owner == OWN_D;
            if (arb) begin
                owner     <= pick_if ? OWN_IF : OWN_D;
                mem_req   <= 1'b1;
                mem_we    <= !pick_if && d_we;
                mem_addr  <= pick_if ? if_addr : d_addr;
                mem_wdata <= pick_if ? '0 : d_wdata;
                mem_wstrb <= (!pick_if && d_we) ? d_wstrb : '0;
            end else if (mem_gnt) begin
                mem_req <= 1'b0;
            end
            if (resp && owner == OWN_IF) if_rdata <= mem_rdata;
            if (resp && owner == OWN_D && !mem_we) d_rdata <= mem_rdata;
        end
    end
    assign if_stall = if_req && !if_done;
    assign d_stall  = d_req && !d_done;
    rvalid_in_txn: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rvalid |-> (state == ARB_WAIT || (state == ARB_ISSUE && mem_gnt)));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural memory of configurable grant/response delay
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic if_req, if_done, if_stall, d_req, d_we, d_done, d_stall;
    logic mem_req, mem_gnt, mem_we, mem_rvalid, hs;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0] d_wstrb, mem_wstrb;
    int tests = 0, fails = 0;
    int gnt_dly = 0, rv_dly = 1;
    logic [31:0] mem [0:1023];
    int gcnt, rcnt;
    logic pend;
    logic [31:0] rd_q, last_load = '0;
    logic [31:0] exp_if[$], exp_d[$];

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] pat(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    assign mem_gnt    = mem_req && gcnt >= gnt_dly;
    assign hs         = mem_req && mem_gnt;
    assign mem_rvalid = rv_dly == 0 ? hs : (pend && rcnt == rv_dly);
    assign mem_rdata  = rv_dly == 0 ? mem[mem_addr[11:2]] : rd_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt <= 0;
            pend <= 1'b0;
            rcnt <= 0;
            rd_q <= '0;
        end else begin
            gcnt <= hs ? 0 : (mem_req ? gcnt + 1 : 0);
            if (pend) begin
                rcnt <= rcnt + 1;
                if (mem_rvalid) pend <= 1'b0;
            end
            if (hs) begin
                rd_q <= mem[mem_addr[11:2]];
                pend <= rv_dly != 0;
                rcnt <= 1;
                for (int b = 0; b < 4; b++)
                    if (mem_we && mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic wait_done(output int cyc, output bit to, output bit ifs);
        cyc = 0;
        ifs = 1'b1;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (!if_done && !if_stall) ifs = 1'b0;
        end while (!if_done && !d_done && cyc < 60);
        to = !if_done && !d_done;
    endtask

    task automatic if_txn(input logic [31:0] a, output int cyc, output bit to);
        bit ifs;
        if_addr = a;
        if_req = 1'b1;
        wait_done(cyc, to, ifs);
        if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic d_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, output int cyc, output bit to);
        bit ifs;
        d_we = we; d_addr = a; d_wdata = wd; d_wstrb = s; d_req = 1'b1;
        wait_done(cyc, to, ifs);
        d_req = 1'b0; d_we = 1'b0; d_wstrb = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int cyc; bit to, ifs; logic [31:0] got;
        tests++;
        if ({mem_req, mem_we, mem_wstrb, if_done, d_done, if_stall, d_stall} !== 10'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 0", {mem_req, mem_we, mem_wstrb, if_done, d_done, if_stall, d_stall});
        end
        tests++;
        if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            fails++;
            $display("FAIL reset_data got %h %h %h %h want 0", mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        gnt_dly = 0; rv_dly = 4;
        if_addr = 32'h8; if_req = 1'b1;
        exp_if.push_back(pat(2));
        repeat (2) @(posedge clk); #1;
        tests++;
        if (dut.state !== ARB_WAIT) begin
            fails++;
            $display("FAIL pre_reset_state got %0d want %0d", dut.state, ARB_WAIT);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0 || dut.state !== ARB_IDLE) begin
            fails++;
            $display("FAIL mid_reset got req=%b ifd=%b dd=%b st=%0d want 0 0 0 0", mem_req, if_done, d_done, dut.state);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_done(cyc, to, ifs);
        got = exp_if.pop_front();
        tests++;
        if (to || !if_done || if_rdata !== got) begin
            fails++;
            $display("FAIL post_reset_fetch got done=%b data=%h want 1 %h", if_done, if_rdata, got);
        end
        if_req = 1'b0;
    endtask

    task automatic test_if_only();
        int cyc; bit to; logic [31:0] got;
        repeat (2) @(posedge clk); #1;
        gnt_dly = 0; rv_dly = 1;
        exp_if.push_back(32'h00A00093);
        if_txn(32'h0, cyc, to);
        got = exp_if.pop_front();
        tests++;
        if (to || cyc != 3) begin
            fails++;
            $display("FAIL if_latency got %0d cycles (timeout=%b) want 3", cyc, to);
        end
        tests++;
        if (if_rdata !== got) begin
            fails++;
            $display("FAIL if_data got %h want %h", if_rdata, got);
        end
        tests++;
        if (if_done !== 1'b0) begin
            fails++;
            $display("FAIL if_done_pulse got %b want 0", if_done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit to, ifs; logic [31:0] got;
        repeat (2) @(posedge clk); #1;
        gnt_dly = 0; rv_dly = 0;
        if_addr = 32'h10; if_req = 1'b1;
        for (int k = 0; k < 3; k++) exp_if.push_back(pat(4 + k));
        for (int k = 0; k < 3; k++) begin
            wait_done(cyc, to, ifs);
            got = exp_if.pop_front();
            tests++;
            if (to || !if_done || if_rdata !== got || cyc != (k == 0 ? 2 : 3) || !ifs) begin
                fails++;
                $display("FAIL b2b_%0d got done=%b data=%h cyc=%0d stall=%b want 1 %h %0d 1",
                         k, if_done, if_rdata, cyc, ifs, got, k == 0 ? 2 : 3);
            end
            if_addr = 32'h14 + 32'(4 * k);
        end
        if_req = 1'b0;
    endtask

    task automatic test_conflict();
        int cyc; bit to, ifs1, ifs2; logic [31:0] got;
        repeat (2) @(posedge clk); #1;
        gnt_dly = 2; rv_dly = 3;
        if_addr = 32'h4; if_req = 1'b1;
        exp_if.push_back(32'h001081B3);
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; d_req = 1'b1;
        exp_d.push_back(last_load);
        #1;
        tests++;
        if (d_stall !== 1'b1 || if_stall !== 1'b1) begin
            fails++;
            $display("FAIL conflict_stall_rise got d=%b if=%b want 1 1", d_stall, if_stall);
        end
        wait_done(cyc, to, ifs1);
        tests++;
        if (to || !d_done || if_done) begin
            fails++;
            $display("FAIL conflict_order got d_done=%b if_done=%b want 1 0", d_done, if_done);
        end
        got = exp_d.pop_front();
        tests++;
        if (d_rdata !== got) begin
            fails++;
            $display("FAIL store_rdata got %h want %h", d_rdata, got);
        end
        d_req = 1'b0; d_we = 1'b0; d_wstrb = '0;
        wait_done(cyc, to, ifs2);
        got = exp_if.pop_front();
        tests++;
        if (to || !if_done || if_rdata !== got) begin
            fails++;
            $display("FAIL conflict_fetch got done=%b data=%h want 1 %h", if_done, if_rdata, got);
        end
        tests++;
        if (!(ifs1 && ifs2)) begin
            fails++;
            $display("FAIL conflict_if_stall got %b%b want 11", ifs1, ifs2);
        end
        tests++;
        if (mem[64] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL conflict_store got %h want deadbeef", mem[64]);
        end
        if_req = 1'b0;
    endtask

    task automatic test_starvation();
        int cyc, nd; bit to, ifs, seen_if; logic [31:0] got;
        repeat (2) @(posedge clk); #1;
        gnt_dly = 0; rv_dly = 1;
        nd = 0; seen_if = 1'b0;
        if_addr = 32'h8; if_req = 1'b1;
        exp_if.push_back(pat(2));
        d_we = 1'b0; d_addr = 32'h300; d_wstrb = '0; d_req = 1'b1;
        exp_d.push_back(pat(192));
        for (int k = 0; k < 8 && !seen_if; k++) begin
            wait_done(cyc, to, ifs);
            if (if_done) begin
                seen_if = 1'b1;
            end else if (d_done) begin
                nd++;
                got = exp_d.pop_front();
                last_load = got;
                tests++;
                if (d_rdata !== got) begin
                    fails++;
                    $display("FAIL starve_load_%0d got %h want %h", nd, d_rdata, got);
                end
                d_addr = 32'h300 + 32'(4 * nd);
                exp_d.push_back(pat(192 + nd));
            end
        end
        tests++;
        if (!seen_if || nd != 4) begin
            fails++;
            $display("FAIL starve_grant got if_seen=%b after %0d loads want 1 after 4", seen_if, nd);
        end
        got = exp_if.pop_front();
        tests++;
        if (if_rdata !== got || dut.starve_cnt !== 4'd0) begin
            fails++;
            $display("FAIL starve_fetch got %h cnt=%0d want %h cnt=0", if_rdata, dut.starve_cnt, got);
        end
        if_req = 1'b0;
        wait_done(cyc, to, ifs);
        got = exp_d.pop_front();
        last_load = got;
        tests++;
        if (to || !d_done || d_rdata !== got) begin
            fails++;
            $display("FAIL starve_tail got done=%b data=%h want 1 %h", d_done, d_rdata, got);
        end
        d_req = 1'b0;
    endtask

    task automatic test_byte_store();
        int cyc; bit to, ifs;
        repeat (2) @(posedge clk); #1;
        gnt_dly = 1; rv_dly = 2;
        mem[128] = 32'h11223344;
        d_txn(1'b1, 32'h200, 32'h0000AB00, 4'b0010, cyc, to);
        tests++;
        if (to || d_rdata !== last_load) begin
            fails++;
            $display("FAIL store_keeps_rdata got %h want %h", d_rdata, last_load);
        end
        tests++;
        if (mem[128] !== 32'h1122AB44) begin
            fails++;
            $display("FAIL byte_merge got %h want 1122ab44", mem[128]);
        end
        d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'hF; d_req = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin
            fails++;
            $display("FAIL load_cmd got req=%b we=%b strb=%h want 1 0 0", mem_req, mem_we, mem_wstrb);
        end
        wait_done(cyc, to, ifs);
        tests++;
        if (to || !d_done || d_rdata !== 32'h1122AB44) begin
            fails++;
            $display("FAIL byte_readback got %h want 1122ab44", d_rdata);
        end
        last_load = 32'h1122AB44;
        d_req = 1'b0; d_wstrb = '0;
    endtask

    task automatic test_program();
        int cyc; bit to; logic [31:0] ins;
        logic [31:0] rf [0:31];
        repeat (2) @(posedge clk); #1;
        gnt_dly = 3; rv_dly = 2;
        for (int r = 0; r < 32; r++) rf[r] = '0;
        for (int pc = 0; pc < 8; pc += 4) begin
            if_txn(32'(pc), cyc, to);
            tests++;
            if (to) begin
                fails++;
                $display("FAIL prog_fetch_%0d got timeout want done", pc);
            end
            ins = if_rdata;
            if (ins[6:0] == 7'h13) rf[ins[11:7]] = rf[ins[19:15]] + {{20{ins[31]}}, ins[31:20]};
            else if (ins[6:0] == 7'h33) rf[ins[11:7]] = rf[ins[19:15]] + rf[ins[24:20]];
        end
        d_txn(1'b1, 32'h380, rf[1], 4'hF, cyc, to);
        d_txn(1'b0, 32'h380, '0, '0, cyc, to);
        tests++;
        if (to || d_rdata !== 32'd10) begin
            fails++;
            $display("FAIL prog_x1 got %0d want 10", d_rdata);
        end
        d_txn(1'b1, 32'h384, rf[3], 4'hF, cyc, to);
        d_txn(1'b0, 32'h384, '0, '0, cyc, to);
        tests++;
        if (to || d_rdata !== 32'd20) begin
            fails++;
            $display("FAIL prog_x3 got %0d want 20", d_rdata);
        end
    endtask

    initial begin
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        mem[0] = 32'h00A00093;
        mem[1] = 32'h001081B3;
        repeat (3) @(posedge clk); #1;
        test_reset();
        test_if_only();
        test_back_to_back();
        test_conflict();
        test_starvation();
        test_byte_store();
        test_program();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end
endmodule
